reg_file_2r1w_pc: RTL and testbench
===================================

Name: reg_file_2r1w_pc

Overview:
- Parametrised register file that generalises the fixed 16-to-1, 32-bit selector into storage plus read ports.
- Contains NUM_REGS registers of WIDTH bits.
- Provides two read ports (A, B), each built from a NUM_REGS-to-1 selector, and one synchronous write port.
- The highest-numbered register is the program counter, with an auto-increment mode.
- Sits between decode and the ALU/operand-select stage of the CPU datapath.

Parameters:
- WIDTH, 32, data width of every register and port.
- NUM_REGS, 16, number of registers; power of two, minimum 2.
- ADDR_W, 4, address width; must equal log2(NUM_REGS).
- PC_INC, 4, amount added to the PC register per enabled cycle.
- REG_OUT, 0, read mode: 0 = combinational read with write bypass; 1 = registered read outputs, one-cycle latency.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  WIDTH  write data.
- ra  input  ADDR_W  read address, port A.
- rb  input  ADDR_W  read address, port B.
- pc_en  input  1  PC auto-increment enable.
- rd_a  output  WIDTH  read data, port A.
- rd_b  output  WIDTH  read data, port B.
- pc_out  output  WIDTH  current value of register NUM_REGS-1, always visible.

Behaviour:
- Reset: on a clock edge with reset=1, all registers clear to 0. With REG_OUT=1 the rd_a/rd_b output registers also clear to 0. Reset overrides we and pc_en in the same cycle. Asserting reset mid-sequence discards any pending write.
- Write: on a rising edge with we=1 and reset=0, reg[wa] <= wd. Takes effect at that edge.
- PC register (index NUM_REGS-1, "PCIDX"):
  - we=1 with wa=PCIDX: reg[PCIDX] <= wd. The explicit write wins over pc_en.
  - Otherwise, if pc_en=1: reg[PCIDX] <= reg[PCIDX] + PC_INC, modulo 2^WIDTH (wraps silently, e.g. 0xFFFFFFFC -> 0x00000000).
  - Otherwise: hold.
- Registers 0..PCIDX-1 have no special behaviour. None are hardwired.
- pc_out = reg[PCIDX], the current stored value. Not bypassed.
- Read, REG_OUT=0:
  - rd_a = (we && wa==ra) ? wd : reg[ra]. Same-cycle write-through bypass. rd_b uses the same rule with rb.
  - Bypass applies to PCIDX too: if we && wa==PCIDX && ra==PCIDX, then rd_a = wd.
  - When pc_en alone is active, the read shows the pre-increment value (no bypass of the increment).
- Read, REG_OUT=1: on each rising edge, rd_a <= the value the REG_OUT=0 expression would produce that cycle (including bypass); same for rd_b. Latency is exactly one cycle from address to data.
- Port independence: ra==rb is legal, and both ports return the same value.
- No X propagation: every address value within 0..NUM_REGS-1 selects a defined register, so no default/latch path is permitted.

Test Plan:
- Reset: run with reset=1 for one edge after random writes -> rd_a, rd_b and pc_out all 0x00000000 on every address. With REG_OUT=1, outputs are 0 on the cycle after reset.
- Write/read all registers: write reg[i] = 0xA5A50000+i for i=0..14, then sweep ra=0..14, rb=14..0 -> rd_a = 0xA5A50000+ra and rd_b = 0xA5A50000+rb. With REG_OUT=1, each value appears one cycle after its address is presented.
- Bypass: reg[3]=0x11111111 stored. Set we=1, wa=3, wd=0x22222222, ra=3, rb=3 in the same cycle -> REG_OUT=0: rd_a = rd_b = 0x22222222 before the edge. Next cycle (we=0) -> 0x22222222.
- PC increment and wrap: write PC=0xFFFFFFF8, then pc_en=1 for 3 cycles -> pc_out reads 0xFFFFFFFC, 0x00000000, 0x00000004.
- PC write priority: pc_out=0x100, pc_en=1, we=1, wa=15, wd=0x2000 -> pc_out=0x2000 next cycle, not 0x104. The following cycle, with we=0, gives 0x2004.
- Reset mid-operation: we=1, wa=5, wd=0xDEADBEEF and reset=1 on the same edge, with pc_en=1 -> reg[5]=0 and pc_out=0. On the next edge, with reset=0 and pc_en=1, pc_out=0x4.

Source files
------------

// File: rtl/reg_file_2r1w_pc.sv
// reg_file_2r1w_pc: NUM_REGS x WIDTH register file, two bypassed read ports, one write port,
// top register doubles as an auto-incrementing program counter.
module reg_file_2r1w_pc #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int PC_INC   = 4,
  parameter bit REG_OUT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              pc_en,
  output logic [WIDTH-1:0]  rd_a,
  output logic [WIDTH-1:0]  rd_b,
  output logic [WIDTH-1:0]  pc_out
);
  localparam int PCIDX = NUM_REGS - 1;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++)
      regs_d[i] = (we && wa == ADDR_W'(i)) ? wd :
                  (i == PCIDX && pc_en)    ? regs_q[i] + WIDTH'(PC_INC) : regs_q[i];
  end
  // Bypass shows the write data on the same cycle; the PC increment is not bypassed.
  always_comb begin
    rd_a_d = (we && wa == ra) ? wd : regs_q[ra];
    rd_b_d = (we && wa == rb) ? wd : regs_q[rb];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end
  assign rd_a   = REG_OUT ? rd_a_q : rd_a_d;
  assign rd_b   = REG_OUT ? rd_b_q : rd_b_d;
  assign pc_out = regs_q[PCIDX];
endmodule

// File: tb/tb_reg_file_2r1w_pc.sv
// tb_reg_file_2r1w_pc: scoreboard bench driving a combinational-read and a registered-read
// instance with identical stimulus, checked against an array-based reference model.
module tb_reg_file_2r1w_pc;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0, pc_en = 1'b0;
  logic [3:0]  wa = '0, ra = '0, rb = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd_a0, rd_b0, pc0, rd_a1, rd_b1, pc1;
  int          n_pass = 0, n_total = 0;

  typedef struct packed {
    logic [31:0] a0, b0, pc, a1, b1;
  } exp_t;
  exp_t        sb_q[$];
  logic [31:0] mdl [16];
  logic [31:0] prev_a = '0, prev_b = '0;

  always #5 clk = ~clk;

  reg_file_2r1w_pc #(.REG_OUT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rb(rb),
    .pc_en(pc_en), .rd_a(rd_a0), .rd_b(rd_b0), .pc_out(pc0));
  reg_file_2r1w_pc #(.REG_OUT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rb(rb),
    .pc_en(pc_en), .rd_a(rd_a1), .rd_b(rd_b1), .pc_out(pc1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("rd_a comb", rd_a0, e.a0);
      chk("rd_b comb", rd_b0, e.b0);
      chk("pc_out comb", pc0, e.pc);
      chk("rd_a reg", rd_a1, e.a1);
      chk("rd_b reg", rd_b1, e.b1);
      chk("pc_out reg", pc1, e.pc);
    end
  end

  task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] x, input logic [3:0] y, input logic p);
    exp_t e;
    logic [31:0] va, vb, npc;
    reset = r; we = w; wa = a; wd = d; ra = x; rb = y; pc_en = p;
    va = (w && a == x) ? d : mdl[x];
    vb = (w && a == y) ? d : mdl[y];
    e.a0 = va; e.b0 = vb; e.pc = mdl[15]; e.a1 = prev_a; e.b1 = prev_b;
    sb_q.push_back(e);
    if (r) begin
      foreach (mdl[i]) mdl[i] = '0;
      prev_a = '0; prev_b = '0;
    end else begin
      npc = p ? mdl[15] + 32'd4 : mdl[15];
      mdl[15] = npc;
      if (w) mdl[a] = d;
      prev_a = va; prev_b = vb;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0);
    // Random writes, then reset, then every address reads back zero.
    for (int i = 0; i < 20; i++)
      step(0, 1, 4'($urandom), $urandom, 4'($urandom), 4'($urandom), 1'($urandom));
    step(1, 1, 4'd7, 32'h12345678, 4'd7, 4'd15, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 4'(i), 4'(15 - i), 0);
    // Fill registers 0..14, then sweep both ports in opposite directions.
    for (int i = 0; i < 15; i++) step(0, 1, 4'(i), 32'hA5A50000 + i, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 4'(i), 4'(14 - i), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Same-cycle write bypass on both ports.
    step(0, 1, 4'd3, 32'h11111111, 0, 0, 0);
    step(0, 1, 4'd3, 32'h22222222, 4'd3, 4'd3, 0);
    step(0, 0, 0, 0, 4'd3, 4'd3, 0);
    step(0, 0, 0, 0, 4'd3, 4'd3, 0);
    // PC wrap.
    step(0, 1, 4'd15, 32'hFFFFFFF8, 4'd15, 4'd15, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 4'd15, 4'd15, 1);
    // Explicit PC write beats increment.
    step(0, 1, 4'd15, 32'h100, 4'd15, 4'd0, 0);
    step(0, 1, 4'd15, 32'h2000, 4'd15, 4'd15, 1);
    step(0, 0, 0, 0, 4'd15, 4'd15, 1);
    step(0, 0, 0, 0, 4'd15, 4'd15, 0);
    // Reset overrides a pending write and PC increment.
    step(0, 1, 4'd5, 32'h55555555, 4'd5, 4'd5, 0);
    step(1, 1, 4'd5, 32'hDEADBEEF, 4'd5, 4'd15, 1);
    step(0, 0, 0, 0, 4'd5, 4'd15, 1);
    step(0, 0, 0, 0, 4'd5, 4'd15, 0);
    for (int i = 0; i < 300; i++) begin
      logic [3:0] a;
      a = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom);
      step(($urandom_range(40) == 0), 1'($urandom), a, $urandom,
           ($urandom_range(2) == 0) ? a : 4'($urandom), 4'($urandom), 1'($urandom));
    end
    @(negedge clk);
    #1;
    n_total++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
